// File: rtl/acq_readout_ctrl.sv
// Capture-RAM sequencer: arms the RAM, waits for the triggered capture, then streams the
// trigger window out over valid/ready. Optional header beat selected by ACQ_HEADER_EN.
module acq_readout_ctrl #(
   parameter int AW      = 12,
   parameter int DW      = 14,
   parameter int ARM_LEN = 4,
   parameter int EN_TMO  = 16
) (
   input  logic          clka,
   input  logic          rstn,
   input  logic          start,
   input  logic          cont,
   input  logic          abort,
   input  logic [AW-1:0] pnts_before,
   input  logic [AW-1:0] pnts_after,
   input  logic          ram_enabled,
   input  logic [AW-1:0] ram_addr_trig,
   input  logic [DW-1:0] ram_dob,
   output logic          ram_rst,
   output logic [AW-1:0] ram_addrb,
   output logic [DW-1:0] m_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic          m_last,
   output logic          busy,
   output logic          err_tmo,
   output logic [15:0]   evt_cnt,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_WAIT_EN  = 3'd2,
      S_WAIT_TRG = 3'd3,
      S_READ     = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   localparam int CMAX = (ARM_LEN > EN_TMO) ? ARM_LEN : EN_TMO;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int LW   = AW + 2;
   localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
`ifdef ACQ_HEADER_EN
   localparam logic HDR_EN = 1'b1;
`else
   localparam logic HDR_EN = 1'b0;
`endif
   localparam logic [LW-1:0] HDR_BEATS = {{(LW-1){1'b0}}, HDR_EN};

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_ram_rst;
   logic          r_err_tmo;
   logic [15:0]   r_evt_cnt;
   logic [AW-1:0] r_pb;
   logic [AW-1:0] r_pa;
   logic [AW-1:0] r_trig;
   logic [AW-1:0] r_addr;
   logic [LW-1:0] r_tot;
   logic [LW-1:0] r_issued;
   logic          r_hdr_todo;
   logic [DW-1:0] r_buf_d [2];
   logic          r_buf_l [2];
   logic          r_head;
   logic [1:0]    r_occ;
   logic          r_pend;
   logic          r_pend_hdr;
   logic          r_pend_last;

   logic [AW:0]   w_sum;
   logic [AW:0]   w_len;
   logic [LW-1:0] w_tot;
   logic          w_pop;
   logic [1:0]    w_fill;
   logic          w_issue;
   logic          w_tail;
   logic [DW-1:0] w_hdr_word;

   // Window length uses an AW+1-bit sum so a full-depth window is not lost to wrap.
   assign w_sum      = {1'b0, r_pb} + {1'b0, r_pa};
   assign w_len      = (w_sum > LEN_MAX) ? LEN_MAX : w_sum;
   assign w_tot      = {1'b0, w_len} + HDR_BEATS;
   assign w_hdr_word = {{(DW-AW){1'b0}}, r_trig};

   assign m_valid = (r_occ != 2'd0);
   assign m_data  = m_valid ? r_buf_d[r_head] : '0;
   assign m_last  = m_valid & r_buf_l[r_head];
   assign w_pop   = (r_state == S_READ) & m_valid & m_ready;

   // Buffer slots still claimed after this cycle's pop; counting the pop keeps 1 beat/cycle.
   assign w_fill  = r_occ + {1'b0, r_pend} - {1'b0, w_pop};
   assign w_issue = (r_state == S_READ) && (w_fill < 2'd2) && (r_issued != r_tot);
   assign w_tail  = r_head ^ r_occ[0];

   assign ram_rst   = r_ram_rst;
   assign ram_addrb = r_addr;
   assign busy      = (r_state != S_IDLE);
   assign err_tmo   = r_err_tmo;
   assign evt_cnt   = r_evt_cnt;
   assign dbg_state = r_state;

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ram_rst   <= 1'b0;
         r_err_tmo   <= 1'b0;
         r_evt_cnt   <= '0;
         r_pb        <= '0;
         r_pa        <= '0;
         r_trig      <= '0;
         r_addr      <= '0;
         r_tot       <= '0;
         r_issued    <= '0;
         r_hdr_todo  <= 1'b0;
         r_buf_d[0]  <= '0;
         r_buf_d[1]  <= '0;
         r_buf_l[0]  <= 1'b0;
         r_buf_l[1]  <= 1'b0;
         r_head      <= 1'b0;
         r_occ       <= '0;
         r_pend      <= 1'b0;
         r_pend_hdr  <= 1'b0;
         r_pend_last <= 1'b0;
      end else if (abort) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_ram_rst   <= 1'b0;
         r_hdr_todo  <= 1'b0;
         r_occ       <= '0;
         r_pend      <= 1'b0;
         r_pend_hdr  <= 1'b0;
         r_pend_last <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_ARM;
                  r_ram_rst <= 1'b1;
                  r_cnt     <= '0;
                  r_err_tmo <= 1'b0;
                  r_pb      <= pnts_before;
                  r_pa      <= pnts_after;
               end
            end
            S_ARM: begin
               if (r_cnt == CW'(ARM_LEN - 1)) begin
                  r_ram_rst <= 1'b0;
                  r_cnt     <= '0;
                  r_state   <= S_WAIT_EN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_EN: begin
               if (ram_enabled) begin
                  r_state <= S_WAIT_TRG;
               end else if (r_cnt == CW'(EN_TMO - 1)) begin
                  r_err_tmo <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_TRG: begin
               // Entered with ram_enabled high, so a low here is the end-of-capture edge.
               if (!ram_enabled) begin
                  r_trig     <= ram_addr_trig;
                  r_addr     <= ram_addr_trig - r_pb;
                  r_tot      <= w_tot;
                  r_issued   <= '0;
                  r_hdr_todo <= HDR_EN;
                  r_head     <= 1'b0;
                  r_state    <= (w_tot == '0) ? S_DONE : S_READ;
               end
            end
            S_READ: begin
               if (r_pend) begin
                  r_buf_d[w_tail] <= r_pend_hdr ? w_hdr_word : ram_dob;
                  r_buf_l[w_tail] <= r_pend_last;
               end
               if (w_pop) begin
                  r_head <= ~r_head;
               end
               r_occ       <= w_fill;
               r_pend      <= w_issue;
               r_pend_hdr  <= w_issue & r_hdr_todo;
               r_pend_last <= w_issue && (r_issued == r_tot - 1'b1);
               if (w_issue) begin
                  r_issued <= r_issued + 1'b1;
                  if (r_hdr_todo) begin
                     r_hdr_todo <= 1'b0;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                  end
               end
               if (w_pop && m_last) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_evt_cnt <= r_evt_cnt + 1'b1;
               if (cont) begin
                  r_state   <= S_ARM;
                  r_ram_rst <= 1'b1;
                  r_cnt     <= '0;
                  r_pb      <= pnts_before;
                  r_pa      <= pnts_after;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
